// File: rtl/press_decoder_pkg.sv
// Shared types and default timing constants for the push-button press decoder.
package press_decoder_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    HOLD   = 3'd2,
    WAIT2  = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  // Defaults in 10 ms ticks of the 100 Hz system clock.
  localparam int LONG_TICKS_DEF = 100;
  localparam int DBL_GAP_DEF    = 30;

endpackage

// File: rtl/press_decoder_if.sv
// Button level in, classified press events out.
interface press_decoder_if;

  logic pb_debounced;
  logic short_press;
  logic long_press;
  logic double_press;
  logic held;

  // Producer of the button level, consumer of the events.
  modport master (
    output pb_debounced,
    input  short_press,
    input  long_press,
    input  double_press,
    input  held
  );

  // The decoder itself.
  modport slave (
    input  pb_debounced,
    output short_press,
    output long_press,
    output double_press,
    output held
  );

endinterface

// File: rtl/press_decoder_edge.sv
// Rise/fall strobes of the debounced button level.
// pb_prev resets to 1 so a button already held through reset yields no rise.
module pb_edge (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic rise,
  output logic fall
);

  logic pb_prev;

  // Previous-sample register, preset to "pressed" on reset.
  always_ff @(posedge clk) begin
    if (rst) pb_prev <= 1'b1;
    else     pb_prev <= pb;
  end

  assign rise = pb & ~pb_prev;
  assign fall = ~pb & pb_prev;

endmodule

// File: rtl/press_decoder.sv
// Classifies debounced button presses into short / long / double events.
// Every event is a registered one-cycle pulse one cycle after its deciding edge.
module press_decoder
  import press_decoder_pkg::*;
#(
  parameter int LONG_TICKS = LONG_TICKS_DEF,
  parameter int DBL_GAP    = DBL_GAP_DEF,
  parameter int CNT_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  press_decoder_if.slave  pb_if
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             short_nxt, long_nxt, dbl_nxt, held_nxt;
  logic             pb, rise, fall;

  assign pb = pb_if.pb_debounced;

  pb_edge u_edge (
    .clk  (clk),
    .rst  (rst),
    .pb   (pb),
    .rise (rise),
    .fall (fall)
  );

  // State, timer and registered event outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      pb_if.short_press  <= 1'b0;
      pb_if.long_press   <= 1'b0;
      pb_if.double_press <= 1'b0;
      pb_if.held         <= 1'b0;
    end else begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      pb_if.short_press  <= short_nxt;
      pb_if.long_press   <= long_nxt;
      pb_if.double_press <= dbl_nxt;
      pb_if.held         <= held_nxt;
    end
  end

  // Next state, timer update and next event values.
  // In PRESS1/HOLD/PRESS2 the previous sample was high, so a low sample is
  // exactly a fall; in WAIT2 the previous sample was low, so high is a rise.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    dbl_nxt   = 1'b0;
    held_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESS1;
          cnt_nxt   = '0;
        end
      end
      PRESS1: begin
        if (fall) begin
          state_nxt = WAIT2;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          held_nxt  = 1'b1;
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (fall) state_nxt = IDLE;
        else      held_nxt  = 1'b1;
      end
      WAIT2: begin
        // A re-press wins over the timeout on the same edge.
        if (rise) begin
          dbl_nxt   = 1'b1;
          state_nxt = PRESS2;
          cnt_nxt   = '0;
        end else if (cnt == GAP_LAST) begin
          short_nxt = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESS2: begin
        if (fall) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: doc/press_decoder.md
Name: press_decoder

Overview:
- Consumer end of the push-button input chain: takes the already-debounced button level and classifies each press.
- Output events are single-cycle pulses: short_press, long_press, double_press, plus a `held` level.
- Runs on the 100 Hz system tick clock, so timing parameters are given in clock cycles (10 ms each).
- Sits between the debouncer and the control FSMs, which use its pulses as command inputs.

Parameters:
- LONG_TICKS, 100, consecutive high samples after press acceptance that classify the press as long (1 s). Must be ≥2.
- DBL_GAP, 30, maximum low samples after a first release within which a second press makes a double (300 ms). Must be ≥2.
- CNT_W, 8, timer width. Must satisfy 2^CNT_W > max(LONG_TICKS, DBL_GAP).

Ports:
- clk  in  1  system clock (100 Hz tick domain)
- rst  in  1  synchronous, active-high reset
- pb_debounced  in  1  debounced button level, synchronous to clk, 1 = pressed
- short_press  out  1  one-cycle pulse: single press, released before LONG_TICKS, no second press within DBL_GAP
- long_press  out  1  one-cycle pulse: press held for LONG_TICKS samples
- double_press  out  1  one-cycle pulse: second press detected within DBL_GAP of first release
- held  out  1  level: high while in HOLD (after long_press until release)

Interface (already decided): one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- All outputs are registered.
- Reset (any cycle, including mid-operation):
  - state←IDLE, cnt←0, all outputs←0, pb_prev←1.
  - Because pb_prev resets to 1, a button held through reset is ignored until it is released and pressed again.
- Edge detection: press edge = pb_debounced & ~pb_prev. pb_prev is updated every cycle.
- Pulses are mutually exclusive, at most one per cycle, each exactly 1 cycle wide. `held` is never high in the same cycle as short_press or double_press.
- Timing reference: T0 is the edge at which the press is accepted; Tr is the edge at which release is seen.
- States and transitions:
  - IDLE:
    - Press edge seen → PRESS1, cnt←0 (this edge is T0).
    - Otherwise stay in IDLE.
  - PRESS1:
    - pb=1 and cnt==LONG_TICKS-1 → long_press=1 next cycle, held←1, go to HOLD.
    - pb=1 otherwise → cnt++.
    - pb=0 → WAIT2, cnt←0 (this edge is Tr).
    - Net effect: long_press is high in the cycle after edge T0+LONG_TICKS, provided pb was 1 at every edge T0+1..T0+LONG_TICKS.
  - HOLD:
    - held=1 while pb=1.
    - pb=0 → IDLE, held←0. No further event is produced.
  - WAIT2:
    - pb=1 → double_press=1 next cycle, go to PRESS2.
    - pb=0 and cnt==DBL_GAP-1 → short_press=1 next cycle, go to IDLE. This gives short_press after edge Tr+DBL_GAP.
    - pb=0 otherwise → cnt++.
  - PRESS2:
    - Wait for pb=0 → IDLE.
    - A long hold in PRESS2 produces no long_press and no held.
- Boundary conditions:
  - Single-cycle press (pb high at T0 only, low at T0+1) is a valid short press.
  - Press lasting exactly LONG_TICKS-1 samples is short; exactly LONG_TICKS samples is long.
  - Re-press at edge Tr+DBL_GAP (the same edge as the timeout) counts as double; the pb=1 check takes priority.
  - cnt never wraps: it is cleared on every state entry and bounded by the compare value.
- Latency: every event pulse appears one cycle after the deciding sample edge.

Decomposition:
- Shared package press_decoder_pkg holds:
  - state encoding: IDLE, PRESS1, HOLD, WAIT2, PRESS2 (3 bits);
  - default tick constants: LONG_TICKS_DEF=100, DBL_GAP_DEF=30.
- One natural sub-module: pb_edge (registers pb_prev, outputs the rise/fall strobes; reset value 1). The FSM and counter stay in press_decoder.

Test Plan (defaults LONG_TICKS=100, DBL_GAP=30):
- Short press: pb high for 5 cycles then low → short_press pulse exactly 1 cycle, 30 edges after release; long_press, double_press and held stay 0.
- Long press: pb high for 150 cycles → long_press after edge T0+100; held high from then until 1 cycle after release; no short_press afterwards.
- Long/short threshold: pb high for exactly 99 samples → short_press. Repeat with exactly 100 samples → long_press.
- Double press: pb high 5, low 29, high 5 → double_press 1 cycle after second rise; no short_press. Repeat with gap 30 → double. Repeat with gap 31 → short_press then a fresh PRESS1 sequence.
- Reset mid-press: assert rst during PRESS1 with pb held high → all outputs 0; no event until pb goes 0 then 1.
- Back-to-back: three quick presses (5 high / 10 low each) → double_press for presses 1+2, then short_press for press 3 (30 edges after its release).
